// File: rtl/alu_pkg.sv
// Shared definitions for the time-shared ALU slice: widths, opcode encodings
// and the sequencer state enum.
package alu_pkg;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [OP_W-1:0] ALU_ADD = 4'd0;
    localparam logic [OP_W-1:0] ALU_SUB = 4'd1;
    localparam logic [OP_W-1:0] ALU_AND = 4'd2;
    localparam logic [OP_W-1:0] ALU_OR  = 4'd3;
    localparam logic [OP_W-1:0] ALU_XOR = 4'd4;
    localparam logic [OP_W-1:0] ALU_SLL = 4'd5;
    localparam logic [OP_W-1:0] ALU_SRL = 4'd6;
    localparam logic [OP_W-1:0] ALU_SRA = 4'd7;
    localparam logic [OP_W-1:0] ALU_SLT = 4'd8;

    // Highest legal opcode; anything above it is treated as illegal.
    localparam logic [OP_W-1:0] ALU_OP_LAST = ALU_SLT;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_unit.sv
// Purely combinational 32-bit ALU. Unknown opcodes produce 0, so the zero
// flag is set for them.
module alu_unit
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    // Opcode decode; shifts use only the low five bits of operand B
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << b[4:0];
            ALU_SRL: result = a >> b[4:0];
            ALU_SRA: result = $signed(a) >>> b[4:0];
            ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one alu_unit between two
// requesters. Define ALU_SHARE_OPCHK_EN to flag opcodes above ALU_OP_LAST
// on rsp_err (result forced to 0, zero forced to 1); otherwise rsp_err is 0.
module alu_share_ctrl
    import alu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_id,
    output logic              rsp_err
);

    state_t            state;
    logic              last_grant;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic              id_q;

    logic              can_accept;
    logic              grant;
    logic              accept;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic [DATA_W-1:0] fin_result;
    logic              fin_zero;
    logic              fin_err;

    // A new request can enter when idle, or when the current response retires
    assign can_accept = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept     = can_accept && (req0_valid || req1_valid);
    assign req0_ready = can_accept && req0_valid && (grant == 1'b0);
    assign req1_ready = can_accept && req1_valid && (grant == 1'b1);

    // Round-robin pick: on contention the requester not granted last time wins
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    alu_unit u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // Final response values, optionally overridden for illegal opcodes
    always_comb begin
        fin_result = alu_result;
        fin_zero   = alu_zero;
        fin_err    = 1'b0;
`ifdef ALU_SHARE_OPCHK_EN
        if (op_q > ALU_OP_LAST) begin
            fin_result = '0;
            fin_zero   = 1'b1;
            fin_err    = 1'b1;
        end
`endif
    end

    // Sequencer: accept -> EXEC (ALU runs on registered operands) -> RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_result <= fin_result;
                    rsp_zero   <= fin_zero;
                    rsp_id     <= id_q;
                    rsp_err    <= fin_err;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= accept ? EXEC : IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                end
            endcase

            if (accept) begin
                last_grant <= grant;
                id_q       <= grant;
                a_q        <= grant ? req1_a  : req0_a;
                b_q        <= grant ? req1_b  : req0_b;
                op_q       <= grant ? req1_op : req0_op;
            end
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed testbench for alu_share_ctrl. Expected rsp_err for illegal opcodes
// follows ALU_SHARE_OPCHK_EN.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    logic              clk;
    logic              rst;
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_id;
    logic              rsp_err;

    int checks;
    int failures;

`ifdef ALU_SHARE_OPCHK_EN
    localparam logic [31:0] EXP_ILLEGAL_ERR = 32'd1;
`else
    localparam logic [31:0] EXP_ILLEGAL_ERR = 32'd0;
`endif

    alu_share_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_zero   (rsp_zero),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err)
    );

    // Free-running 10-unit clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(
        input logic              v0,
        input logic [DATA_W-1:0] a0,
        input logic [DATA_W-1:0] b0,
        input logic [OP_W-1:0]   op0,
        input logic              v1,
        input logic [DATA_W-1:0] a1,
        input logic [DATA_W-1:0] b1,
        input logic [OP_W-1:0]   op1,
        input logic              rr
    );
        req0_valid = v0;
        req0_a     = a0;
        req0_b     = b0;
        req0_op    = op0;
        req1_valid = v1;
        req1_a     = a1;
        req1_b     = b1;
        req1_op    = op1;
        rsp_ready  = rr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs(input logic rr);
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, '0, '0, rr);
    endtask

    // Directed sequence of transactions with hand-computed results
    initial begin
        checks   = 0;
        failures = 0;

        rst = 1'b1;
        idleInputs(1'b0);
        step();
        step();
        rst = 1'b0;
        checkOutput("reset_rsp_valid",  32'(rsp_valid),  32'd0);
        checkOutput("reset_rsp_result", rsp_result,      32'd0);
        checkOutput("reset_rsp_zero",   32'(rsp_zero),   32'd0);
        checkOutput("reset_rsp_id",     32'(rsp_id),     32'd0);
        checkOutput("reset_rsp_err",    32'(rsp_err),    32'd0);

        // ADD 5+7 from req0, latency check
        applyStimulus(1'b1, 32'd5, 32'd7, ALU_ADD, 1'b0, '0, '0, '0, 1'b1);
        checkOutput("add_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("add_req1_ready", 32'(req1_ready), 32'd0);
        step();
        idleInputs(1'b1);
        checkOutput("add_exec_valid", 32'(rsp_valid), 32'd0);
        step();
        checkOutput("add_rsp_valid",  32'(rsp_valid),  32'd1);
        checkOutput("add_rsp_result", rsp_result,      32'd12);
        checkOutput("add_rsp_zero",   32'(rsp_zero),   32'd0);
        checkOutput("add_rsp_id",     32'(rsp_id),     32'd0);
        step();
        checkOutput("add_back_idle", 32'(rsp_valid), 32'd0);

        // Contention right after reset: req0 first, req1 on the handshake cycle
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1'b1, 32'h0000_F0F0, 32'h0000_FF00, ALU_AND,
                      1'b1, 32'd9, 32'd9, ALU_SUB, 1'b1);
        checkOutput("cont_req0_ready", 32'(req0_ready), 32'd1);
        checkOutput("cont_req1_ready", 32'(req1_ready), 32'd0);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'd9, 32'd9, ALU_SUB, 1'b1);
        checkOutput("cont_exec_req1_ready", 32'(req1_ready), 32'd0);
        step();
        checkOutput("cont_rsp0_valid",  32'(rsp_valid), 32'd1);
        checkOutput("cont_rsp0_result", rsp_result,     32'h0000_F000);
        checkOutput("cont_rsp0_id",     32'(rsp_id),    32'd0);
        checkOutput("cont_resp_req1_ready", 32'(req1_ready), 32'd1);
        step();
        idleInputs(1'b1);
        checkOutput("cont_nobubble_exec_valid", 32'(rsp_valid), 32'd0);
        step();
        checkOutput("cont_rsp1_valid",  32'(rsp_valid), 32'd1);
        checkOutput("cont_rsp1_result", rsp_result,     32'd0);
        checkOutput("cont_rsp1_zero",   32'(rsp_zero),  32'd1);
        checkOutput("cont_rsp1_id",     32'(rsp_id),    32'd1);
        step();

        // SRA with response backpressure; req1 waits during the stall
        applyStimulus(1'b1, 32'h8000_0000, 32'd4, ALU_SRA, 1'b0, '0, '0, '0, 1'b0);
        step();
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h0000_00FF, 32'h0000_000F, ALU_XOR, 1'b0);
        step();
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_rsp_valid",  32'(rsp_valid),  32'd1);
            checkOutput("stall_rsp_result", rsp_result,      32'hF800_0000);
            checkOutput("stall_rsp_id",     32'(rsp_id),     32'd0);
            checkOutput("stall_req0_ready", 32'(req0_ready), 32'd0);
            checkOutput("stall_req1_ready", 32'(req1_ready), 32'd0);
            step();
        end
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'h0000_00FF, 32'h0000_000F, ALU_XOR, 1'b1);
        checkOutput("release_req1_ready", 32'(req1_ready), 32'd1);
        step();
        idleInputs(1'b1);
        checkOutput("release_exec_valid", 32'(rsp_valid), 32'd0);
        step();
        checkOutput("xor_rsp_result", rsp_result,  32'h0000_00F0);
        checkOutput("xor_rsp_id",     32'(rsp_id), 32'd1);
        step();
        checkOutput("xor_back_idle", 32'(rsp_valid), 32'd0);

        // Illegal opcode 4'b1010
        applyStimulus(1'b1, 32'h0000_1234, 32'h0000_5678, 4'b1010, 1'b0, '0, '0, '0, 1'b1);
        checkOutput("ill_req0_ready", 32'(req0_ready), 32'd1);
        step();
        idleInputs(1'b1);
        step();
        checkOutput("ill_rsp_valid",  32'(rsp_valid), 32'd1);
        checkOutput("ill_rsp_result", rsp_result,     32'd0);
        checkOutput("ill_rsp_zero",   32'(rsp_zero),  32'd1);
        checkOutput("ill_rsp_err",    32'(rsp_err),   EXP_ILLEGAL_ERR);
        step();

        // Signed SLT from req1 alone
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 32'hFFFF_FFFF, 32'd1, ALU_SLT, 1'b1);
        checkOutput("slt_req1_ready", 32'(req1_ready), 32'd1);
        checkOutput("slt_req0_ready", 32'(req0_ready), 32'd0);
        step();
        idleInputs(1'b1);
        step();
        checkOutput("slt_rsp_result", rsp_result,    32'd1);
        checkOutput("slt_rsp_zero",   32'(rsp_zero), 32'd0);
        checkOutput("slt_rsp_err",    32'(rsp_err),  32'd0);
        step();

        // Reset during EXEC discards the transaction
        applyStimulus(1'b1, 32'd1, 32'd2, ALU_ADD, 1'b0, '0, '0, '0, 1'b1);
        step();
        rst = 1'b1;
        idleInputs(1'b1);
        step();
        rst = 1'b0;
        checkOutput("rstexec_valid_a", 32'(rsp_valid), 32'd0);
        step();
        checkOutput("rstexec_valid_b", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b1, 32'd3, 32'd4, ALU_ADD, 1'b0, '0, '0, '0, 1'b1);
        step();
        idleInputs(1'b1);
        checkOutput("post_rst_exec_valid", 32'(rsp_valid), 32'd0);
        step();
        checkOutput("post_rst_rsp_valid",  32'(rsp_valid), 32'd1);
        checkOutput("post_rst_rsp_result", rsp_result,     32'd7);
        checkOutput("post_rst_rsp_id",     32'(rsp_id),    32'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester arbiter and sequencer that time-shares one 32-bit ALU instance (`alu_unit`) between independent clients, e.g. the execute stage and the branch/address-compare path. It accepts operand/opcode transactions over valid/ready, grants them round-robin, registers operands, captures the ALU result and zero flag, and returns them on a single tagged response channel with backpressure.

## Interface
- DATA_W, 32, operand/result width; fixed at 32 to match the ALU
- OP_W, 4, ALU opcode width
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous reset, active-high
- req0_valid / req1_valid  in  1  requester 0/1 has a transaction
- req0_ready / req1_ready  out  1  requester 0/1 transaction accepted this cycle
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands A and B
- req0_op / req1_op  in  OP_W  ALU opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT
- rsp_valid  out  1  response valid
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  DATA_W  captured ALU output
- rsp_zero  out  1  captured zero flag
- rsp_id  out  1  requester index that issued this result
- rsp_err  out  1  illegal opcode flag (see Configuration)

## Operation
- FSM states: IDLE, EXEC, RESP.
- can_accept = (state==IDLE) || (state==RESP && rsp_ready).
- Arbitration in every can_accept cycle: one valid requester is granted. If both are valid, the requester not named by last_grant is granted. reqN_ready = can_accept && grant==N; ready depends combinationally on both valids. Requesters must not make valid depend on ready.
- On acceptance: a_q, b_q, op_q, id_q are loaded, last_grant is set to the granted index, and the next state is EXEC.
- EXEC: the ALU is driven from a_q/b_q/op_q. At the clock edge, rsp_result, rsp_zero, rsp_id and rsp_err are registered. The next state is RESP.
- RESP: rsp_valid=1 and all rsp_* outputs stay stable until rsp_ready. On handshake the next state is EXEC if a new request is accepted in the same cycle, otherwise IDLE.
- IDLE with no valid request: the FSM stays in IDLE and last_grant is unchanged.
- A requester that is valid but not ready must hold its payload; the block samples the payload only in the acceptance cycle.

## Timing
- Reset values: state=IDLE; rsp_valid=0; rsp_result=0; rsp_zero=0; rsp_id=0; rsp_err=0; last_grant=1, so requester 0 wins the first contention. req*_ready reset to 0 only via state; after reset the block is in IDLE and readies follow the arbitration rule.
- Latency: request accepted at edge N produces rsp_valid high in cycle N+2.
- Throughput: one transaction per 2 cycles when rsp_ready is held high.
- Starvation: under continuous contention, grants strictly alternate 0,1,0,1.
- Reset asserted in any state: the in-flight transaction is discarded, no response is produced, and all registers take their reset values on the next edge.
- Simultaneous rsp handshake and new request in RESP: the old response retires and the new request is accepted in the same cycle; there is no bubble cycle.

## Configuration
- ALU_SHARE_OPCHK_EN defined: an opcode ≥ 9 sets rsp_err=1 and forces rsp_result=0 and rsp_zero=1. The transaction still completes normally with the same latency.
- ALU_SHARE_OPCHK_EN undefined: rsp_err is tied 0. An illegal opcode yields the ALU default result of 0 with rsp_zero=1.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (ALU_ADD … ALU_SLT);
  - ALU_OP_LAST=8;
  - the FSM state enum;
  - DATA_W default.
- One sub-module: the existing `alu_unit`, instantiated once and fed only from the operand registers.
- Round-robin logic stays inline in alu_share_ctrl; no separate module is needed.

## Test plan
- After reset, req0 ADD a=5, b=7 accepted at edge N → rsp_valid in cycle N+2 with rsp_result=12, rsp_zero=0, rsp_id=0.
- Both requesters valid in the first cycle after reset → req0 granted first. req1 is granted on the RESP handshake cycle; responses carry rsp_id 0 then 1.
- req1 SUB a=9, b=9 → rsp_result=0, rsp_zero=1. SRA a=0x80000000, b=4 → 0xF8000000.
- rsp_ready held low for 3 cycles in RESP → rsp_* stable and both req*_ready low throughout. Release → handshake, then return to IDLE.
- With the macro defined, op=4'b1010 → rsp_err=1, rsp_result=0, rsp_zero=1. With the macro undefined → rsp_err=0.
- rst asserted during EXEC → rsp_valid never rises for that transaction. The next req0 after reset completes with normal 2-cycle latency.
